// File: rtl/pll_rst_seq.sv
// Purpose : reset/lock sequencer for the PLL wrapper; holds user logic in reset until lock is stable.
// Latency : user_rst_n rises LOCK_STABLE_CYCLES+2 sys_clk edges after pll_lock is first sampled high.
// Backpressure: none; pll_lock is observed every cycle and soft_rst is honoured in any state.
//
// Ports:
//   sys_clk       PLL reference clock (free running)
//   sys_rst_n     async active-low reset
//   soft_rst      sync request to re-run the full sequence
//   pll_lock      async PLL lock, 2-flop synchronised to lock_s
//   pll_rst       active-high PLL reset
//   user_rst_n    active-low reset for downstream sys_clk logic
//   pll_ready     high only while running with stable lock
//   fail          sticky: no lock within MAX_RETRY+1 attempts
//   retry_cnt     lock timeouts in the current sequence
//   lock_loss_cnt lock drops seen while running, saturating
module pll_rst_seq #(
  parameter int RST_CYCLES          = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 125000,
  parameter int MAX_RETRY           = 3,
  parameter int CNT_W               = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       soft_rst,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic       user_rst_n,
  output logic       pll_ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RUN,
    ST_FAIL
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRY);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rcnt, rcnt_nxt;
  logic [CNT_W-1:0] tcnt, tcnt_nxt;
  logic [CNT_W-1:0] scnt, scnt_nxt;
  logic [3:0]       retry_nxt;
  logic [7:0]       loss_nxt;
  logic             lock_m, lock_s;
  logic             run_go, timeout;

  // RUN entry is only possible from STABLE; it beats a coincident timeout.
  assign run_go  = (state == ST_STABLE) && lock_s && (scnt == STABLE_LAST);
  assign timeout = (tcnt == TIMEOUT_LAST);

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    tcnt_nxt  = tcnt;
    scnt_nxt  = scnt;
    retry_nxt = retry_cnt;
    loss_nxt  = lock_loss_cnt;
    if (soft_rst) begin
      state_nxt = ST_RESET;
      rcnt_nxt  = '0;
      retry_nxt = '0;
    end else begin
      case (state)
        ST_RESET: begin
          if (rcnt == RST_LAST) begin
            state_nxt = ST_WAIT_LOCK;
            tcnt_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt + 1'b1;
          end
        end
        ST_WAIT_LOCK, ST_STABLE: begin
          // tcnt spans both states so a flickering lock still times out
          tcnt_nxt = tcnt + 1'b1;
          if (run_go) begin
            state_nxt = ST_RUN;
            retry_nxt = '0;
          end else if (timeout) begin
            if (retry_cnt == RETRY_MAX) begin
              state_nxt = ST_FAIL;
            end else begin
              state_nxt = ST_RESET;
              rcnt_nxt  = '0;
              retry_nxt = retry_cnt + 1'b1;
            end
          end else if (state == ST_WAIT_LOCK) begin
            if (lock_s) begin
              state_nxt = ST_STABLE;
              scnt_nxt  = '0;
            end
          end else if (lock_s) begin
            scnt_nxt = scnt + 1'b1;
          end else begin
            state_nxt = ST_WAIT_LOCK;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_nxt = ST_RESET;
            rcnt_nxt  = '0;
            if (lock_loss_cnt != 8'hFF) loss_nxt = lock_loss_cnt + 1'b1;
          end
        end
        ST_FAIL: state_nxt = ST_FAIL;
        default: begin
          state_nxt = ST_RESET;
          rcnt_nxt  = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= ST_RESET;
      rcnt          <= '0;
      tcnt          <= '0;
      scnt          <= '0;
      lock_m        <= 1'b0;
      lock_s        <= 1'b0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
      pll_rst       <= 1'b1;
      user_rst_n    <= 1'b0;
      pll_ready     <= 1'b0;
      fail          <= 1'b0;
    end else begin
      lock_m        <= pll_lock;
      lock_s        <= lock_m;
      state         <= state_nxt;
      rcnt          <= rcnt_nxt;
      tcnt          <= tcnt_nxt;
      scnt          <= scnt_nxt;
      retry_cnt     <= retry_nxt;
      lock_loss_cnt <= loss_nxt;
      pll_rst       <= (state_nxt == ST_RESET) || (state_nxt == ST_FAIL);
      user_rst_n    <= (state_nxt == ST_RUN);
      pll_ready     <= (state_nxt == ST_RUN);
      fail          <= (state_nxt == ST_FAIL);
    end
  end

endmodule
